// File: rtl/unified_mem_pkg.sv
// Shared encodings and helpers for the unified I/D memory arbiter.
package unified_mem_pkg;

    localparam logic [1:0]  SZ_NONE      = 2'b00;
    localparam logic [1:0]  SZ_B         = 2'b01;
    localparam logic [1:0]  SZ_H         = 2'b10;
    localparam logic [1:0]  SZ_W         = 2'b11;
    localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        RK_NONE  = 2'b00,
        RK_FETCH = 2'b01,
        RK_LOAD  = 2'b10
    } rkind_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] d;
        case (size)
            SZ_B:    d = {4{data[7:0]}};
            SZ_H:    d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load-return alignment: picks the addressed byte/half out of the SRAM word and extends it.
module mem_lane_align
    import unified_mem_pkg::*;
(
    input  logic [31:0] mrdata,
    input  logic [1:0]  r_off,
    input  logic [1:0]  r_size,
    input  logic        r_se,
    input  logic        r_bad,
    output logic [31:0] datai
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        shifted = mrdata >> {r_off, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = r_off[1] ? mrdata[31:16] : mrdata[15:0];
        datai   = '0;
        if (!r_bad) begin
            case (r_size)
                SZ_B:    datai = r_se ? {{24{byte_s[7]}}, byte_s}  : {24'h0, byte_s};
                SZ_H:    datai = r_se ? {{16{half_s[15]}}, half_s} : {16'h0, half_s};
                SZ_W:    datai = mrdata;
                default: datai = '0;
            endcase
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port SRAM shared by fetch and data ports; data always wins, fetch gets a NOP and IVALID=0.
module unified_mem_arbiter
    import unified_mem_pkg::*;
#(
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [31:0]       IADDR,
    output logic [31:0]       IDATA,
    output logic              IVALID,
    input  logic [31:0]       DADDR,
    input  logic [31:0]       DATAO,
    input  logic [1:0]        DWE,
    input  logic [1:0]        DRE,
    input  logic              DSE,
    output logic [31:0]       DATAI,
    output logic              MCE,
    output logic [ADDR_W-1:0] MADDR,
    output logic [3:0]        MWE,
    output logic [31:0]       MWDATA,
    input  logic [31:0]       MRDATA,
    output logic              MISALIGN,
    output logic [31:0]       FSTALL_CNT
);

    logic       d_wr, d_req, d_bad;
    logic [1:0] d_size;

    rkind_e      r_kind_q, r_kind_d;
    logic [1:0]  r_off_q, r_off_d;
    logic [1:0]  r_size_q, r_size_d;
    logic        r_se_q, r_se_d;
    logic        r_bad_q, r_bad_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fstall_q, fstall_d;
    logic        lane_kill;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{IADDR[31:ADDR_W+2], DADDR[31:ADDR_W+2]};

    // Issue stage: classify the data request; a store with DRE also set is still a store.
    always_comb begin
        d_wr   = (DWE != SZ_NONE);
        d_size = d_wr ? DWE : DRE;
        d_req  = (d_size != SZ_NONE);
        d_bad  = ((d_size == SZ_H) && DADDR[0]) ||
                 ((d_size == SZ_W) && (DADDR[1:0] != 2'b00));
    end

    always_comb begin
        MCE    = RSTN && !(d_req && d_bad);
        MADDR  = d_req ? DADDR[ADDR_W+1:2] : IADDR[ADDR_W+1:2];
        MWE    = (RSTN && d_wr && !d_bad) ? lane_mask(DWE, DADDR[1:0]) : 4'b0000;
        MWDATA = lane_data(DWE, DATAO);
    end

    always_comb begin
        r_kind_d   = d_req ? (d_wr ? RK_NONE : RK_LOAD) : RK_FETCH;
        r_off_d    = DADDR[1:0];
        r_size_d   = DRE;
        r_se_d     = DSE;
        r_bad_d    = d_req && d_bad;
        misalign_d = misalign_q || (d_req && d_bad) ||
                     (!d_req && (IADDR[1:0] != 2'b00));
        fstall_d   = (d_req && (fstall_q != 32'hFFFF_FFFF)) ? fstall_q + 32'd1 : fstall_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_kind_q   <= RK_NONE;
            r_off_q    <= '0;
            r_size_q   <= '0;
            r_se_q     <= 1'b0;
            r_bad_q    <= 1'b0;
            misalign_q <= 1'b0;
            fstall_q   <= '0;
        end else begin
            r_kind_q   <= r_kind_d;
            r_off_q    <= r_off_d;
            r_size_q   <= r_size_d;
            r_se_q     <= r_se_d;
            r_bad_q    <= r_bad_d;
            misalign_q <= misalign_d;
            fstall_q   <= fstall_d;
        end
    end

    // Return stage: SRAM data from the previous issue is steered to whichever port owned it.
    always_comb begin
        IVALID     = (r_kind_q == RK_FETCH);
        IDATA      = IVALID ? MRDATA : NOP_INSN;
        lane_kill  = r_bad_q || (r_kind_q != RK_LOAD);
        MISALIGN   = misalign_q;
        FSTALL_CNT = fstall_q;
    end

    mem_lane_align u_align (
        .mrdata (MRDATA),
        .r_off  (r_off_q),
        .r_size (r_size_q),
        .r_se   (r_se_q),
        .r_bad  (lane_kill),
        .datai  (DATAI)
    );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: SRAM model plus a byte-level shadow memory reference.
module tb_unified_mem_arbiter;

    localparam int          AW  = 14;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic [31:0]   IADDR = '0, DADDR = '0, DATAO = '0;
    logic [1:0]    DWE = '0, DRE = '0;
    logic          DSE = 1'b0;
    logic [31:0]   IDATA, DATAI, MWDATA, FSTALL_CNT;
    logic          IVALID, MCE, MISALIGN;
    logic [AW-1:0] MADDR;
    logic [3:0]    MWE;
    logic [31:0]   MRDATA = '0;

    logic [31:0] sram   [0:(1<<AW)-1];
    logic [31:0] shadow [0:(1<<AW)-1];

    logic        m_ivalid, m_mis;
    logic [31:0] m_idata, m_datai, m_fst;
    int          ncmp = 0;
    int          nerr = 0;
    int          nvec = 0;

    unified_mem_arbiter #(.ADDR_W(AW), .NOP_INSN(NOP)) dut (
        .CLK(CLK), .RSTN(RSTN), .IADDR(IADDR), .IDATA(IDATA), .IVALID(IVALID),
        .DADDR(DADDR), .DATAO(DATAO), .DWE(DWE), .DRE(DRE), .DSE(DSE), .DATAI(DATAI),
        .MCE(MCE), .MADDR(MADDR), .MWE(MWE), .MWDATA(MWDATA), .MRDATA(MRDATA),
        .MISALIGN(MISALIGN), .FSTALL_CNT(FSTALL_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        logic [31:0] w;
        if (MCE) begin
            w = sram[MADDR];
            for (int i = 0; i < 4; i++)
                if (MWE[i]) w[8*i +: 8] = MWDATA[8*i +: 8];
            if (MWE != 4'b0000) sram[MADDR] <= w;
            MRDATA <= sram[MADDR];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ivalid = 1'b0;
        m_idata  = NOP;
        m_datai  = '0;
        m_mis    = 1'b0;
        m_fst    = '0;
    endtask

    task automatic check_returns();
        chk("ivalid",   {31'h0, IVALID},   {31'h0, m_ivalid});
        chk("idata",    IDATA,             m_idata);
        chk("datai",    DATAI,             m_datai);
        chk("misalign", {31'h0, MISALIGN}, {31'h0, m_mis});
        chk("fstall",   FSTALL_CNT,        m_fst);
    endtask

    // One cycle: drive at posedge+1, check issue outputs at negedge, check returns after the edge.
    task automatic step(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dout,
                        input logic [1:0] we, input logic [1:0] re, input logic se);
        logic        is_wr, dreq, bad;
        logic [1:0]  sz;
        int          nb, off, wa, fa;
        logic [63:0] v, msk;
        logic [3:0]  emwe;
        logic [31:0] emwd;
        IADDR = ia; DADDR = da; DATAO = dout; DWE = we; DRE = re; DSE = se;
        is_wr = (we != 2'b00);
        sz    = is_wr ? we : re;
        dreq  = (sz != 2'b00);
        nb    = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
        off   = int'(da % 4);
        bad   = dreq && ((da % nb) != 0);
        wa    = int'((da >> 2) % (1 << AW));
        fa    = int'((ia >> 2) % (1 << AW));
        emwe  = (is_wr && !bad) ? 4'(((1 << nb) - 1) << off) : 4'b0000;
        for (int i = 0; i < 4; i++) emwd[8*i +: 8] = dout[8*(i % nb) +: 8];
        @(negedge CLK);
        chk("mce",   {31'h0, MCE}, {31'h0, !(dreq && bad)});
        chk("maddr", 32'(MADDR),   dreq ? wa : fa);
        chk("mwe",   32'(MWE),     32'(emwe));
        if (is_wr) chk("mwdata", MWDATA, emwd);
        if (!dreq) begin
            m_ivalid = 1'b1;
            m_idata  = shadow[fa];
            m_datai  = '0;
            if ((ia % 4) != 0) m_mis = 1'b1;
        end else begin
            m_ivalid = 1'b0;
            m_idata  = NOP;
            m_datai  = '0;
            if (bad) m_mis = 1'b1;
            if (m_fst != 32'hFFFF_FFFF) m_fst = m_fst + 1;
            if (!is_wr && !bad) begin
                v = 64'(shadow[wa]) >> (8 * off);
                if (nb < 4) begin
                    msk = (64'd1 << (8 * nb)) - 1;
                    v   = v & msk;
                    if (se && v[8*nb-1]) v = v | ~msk;
                end
                m_datai = v[31:0];
            end
            if (is_wr && !bad)
                for (int i = 0; i < 4; i++)
                    if (emwe[i]) shadow[wa][8*i +: 8] = emwd[8*i +: 8];
        end
        @(posedge CLK);
        #1;
        nvec++;
        check_returns();
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        DWE = 2'b11; DRE = 2'b01; DADDR = 32'h100; DATAO = 32'hFFFF_FFFF; IADDR = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_mce",   {31'h0, MCE},      32'h0);
        chk("rst_mwe",   32'(MWE),          32'h0);
        chk("rst_ivld",  {31'h0, IVALID},   32'h0);
        chk("rst_idata", IDATA,             NOP);
        chk("rst_datai", DATAI,             32'h0);
        chk("rst_mis",   {31'h0, MISALIGN}, 32'h0);
        chk("rst_fst",   FSTALL_CNT,        32'h0);
        DWE = 2'b00; DRE = 2'b00;
        RSTN = 1'b1;
        #1;
        chk("c1_ivld",  {31'h0, IVALID}, 32'h0);
        chk("c1_idata", IDATA,           NOP);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]   = '0;
            shadow[i] = '0;
        end
        sram[0]   = 32'h0050_0093;
        shadow[0] = 32'h0050_0093;

        do_reset();
        step(32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        chk("c2_ivld",  {31'h0, IVALID}, 32'h1);
        chk("c2_idata", IDATA,           32'h0050_0093);

        step(32'h4, 32'h102, 32'h0000_00AB, 2'b01, 2'b00, 1'b0);
        chk("sb_ivld", {31'h0, IVALID}, 32'h0);
        chk("sb_fst",  FSTALL_CNT,      32'h1);
        step(32'h4, 32'h100, 32'h80FF_7F01, 2'b11, 2'b00, 1'b0);

        step(32'h4, 32'h102, 32'h0, 2'b00, 2'b10, 1'b1);
        chk("lh_s", DATAI, 32'hFFFF_80FF);
        step(32'h4, 32'h102, 32'h0, 2'b00, 2'b10, 1'b0);
        chk("lh_u", DATAI, 32'h0000_80FF);
        step(32'h4, 32'h101, 32'h0, 2'b00, 2'b01, 1'b1);
        chk("lb_7f", DATAI, 32'h0000_007F);
        step(32'h4, 32'h103, 32'h0, 2'b00, 2'b01, 1'b1);
        chk("lb_80", DATAI, 32'hFFFF_FF80);

        step(32'h4, 32'h102, 32'hDEAD_BEEF, 2'b11, 2'b00, 1'b0);
        chk("mis_set", {31'h0, MISALIGN}, 32'h1);
        step(32'h4, 32'h100, 32'h0, 2'b00, 2'b11, 1'b0);
        chk("mis_nowr", DATAI, 32'h80FF_7F01);
        step(32'h4, 32'h101, 32'h0, 2'b00, 2'b10, 1'b1);
        chk("mis_ld0", DATAI, 32'h0);
        step(32'h8, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        chk("mis_hold", {31'h0, MISALIGN}, 32'h1);

        do_reset();
        step(32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(32'h4, 32'h100, 32'h0, 2'b00, 2'b11, 1'b0);
            chk("run_ivld", {31'h0, IVALID}, 32'h0);
        end
        chk("run_fst", FSTALL_CNT, 32'h5);
        step(32'h4, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        chk("resume_ivld", {31'h0, IVALID}, 32'h1);

        step(32'h8, 32'h100, 32'h0, 2'b00, 2'b11, 1'b0);
        step(32'h8, 32'h100, 32'h0, 2'b00, 2'b11, 1'b0);
        #2;
        RSTN = 1'b0;
        #1;
        model_reset();
        chk("ar_ivld",  {31'h0, IVALID}, 32'h0);
        chk("ar_datai", DATAI,           32'h0);
        chk("ar_fst",   FSTALL_CNT,      32'h0);
        chk("ar_idata", IDATA,           NOP);
        chk("ar_mce",   {31'h0, MCE},    32'h0);
        @(posedge CLK);
        #1;
        DWE = 2'b00; DRE = 2'b00;
        RSTN = 1'b1;
        #1;

        for (int k = 0; k < 400; k++) begin
            logic [31:0] ia, da, dout;
            logic [1:0]  we, re;
            int          r;
            ia   = $urandom_range(0, 63) * 4;
            if ($urandom_range(0, 19) == 0) ia = ia + $urandom_range(1, 3);
            da   = $urandom_range(0, 255);
            dout = $urandom;
            r    = $urandom_range(0, 7);
            we   = 2'b00;
            re   = 2'b00;
            if (r == 3 || r == 4) re = 2'($urandom_range(1, 3));
            if (r == 5 || r == 6) we = 2'($urandom_range(1, 3));
            if (r == 7) begin
                we = 2'($urandom_range(1, 3));
                re = 2'($urandom_range(1, 3));
            end
            step(ia, da, dout, we, re, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, synchronous-read unified SRAM between the core's instruction-fetch port and its data port.
- Sits between riscv_core and the memory macro.
- Data accesses from the M stage always win. A fetch that loses arbitration returns IVALID=0 next cycle, and a NOP is substituted on IDATA.
- Also performs byte-lane steering for stores, alignment and sign-extension of load data, misalignment detection, and a fetch-stall performance counter.

Parameters:
- ADDR_W, 14, word-address width of the SRAM (2^ADDR_W 32-bit words).
- NOP_INSN, 32'h00000013, instruction driven on IDATA when no fetch data is returned.

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset
- IADDR  in  32  fetch byte address from core
- IDATA  out  32  fetched instruction to core
- IVALID  out  1  IDATA holds fetch data for the IADDR issued the previous cycle
- DADDR  in  32  data byte address from core
- DATAO  in  32  store data, right-aligned
- DWE  in  2  store size: 00 none, 01 byte, 10 half, 11 word
- DRE  in  2  load size, same encoding
- DSE  in  1  load sign extend: 1 signed, 0 unsigned
- DATAI  out  32  aligned/extended load data to core WB mux
- MCE  out  1  SRAM chip enable
- MADDR  out  ADDR_W  SRAM word address
- MWE  out  4  SRAM byte write enables, bit i = byte lane i
- MWDATA  out  32  SRAM write data
- MRDATA  in  32  SRAM read data, valid the cycle after a read
- MISALIGN  out  1  sticky misaligned-access flag
- FSTALL_CNT  out  32  fetch cycles lost to data accesses, saturating

Behaviour:
- Clock and reset: one clock, CLK. RSTN is asynchronous and active-low.
- Reset values: all registers clear. While RSTN=0, the outputs are:
  - MCE=0, MWE=0, IVALID=0
  - IDATA=NOP_INSN, DATAI=0
  - MISALIGN=0, FSTALL_CNT=0
- Issue (combinational, cycle t):
  - Data request = DWE!=0 or DRE!=0. If DWE and DRE are both non-zero, the access is a write and DRE is ignored.
  - Data granted: MCE=1, MADDR=DADDR[ADDR_W+1:2].
  - Fetch granted (no data request): MCE=1, MADDR=IADDR[ADDR_W+1:2], MWE=0.
  - Fetch is requested every cycle out of reset.
- Store lanes:
  - byte: MWE = 1<<DADDR[1:0], MWDATA = {4{DATAO[7:0]}}.
  - half: MWE = DADDR[1] ? 1100 : 0011, MWDATA = {2{DATAO[15:0]}}.
  - word: MWE = 1111, MWDATA = DATAO.
  - For loads, MWE = 0.
- Misalignment:
  - A data access is misaligned for half with DADDR[0]=1, or word with DADDR[1:0]!=0.
  - A misaligned data access is still granted the slot (the fetch stalls) but MCE=0, so nothing is written.
  - A misaligned load returns DATAI=0. MISALIGN sets on the next edge.
  - A fetch with IADDR[1:0]!=0 also sets MISALIGN; it is fetched from the truncated word address.
- Return registers, captured at edge t:
  - r_kind: NONE / FETCH / LOAD.
  - r_off = DADDR[1:0], r_size = DRE, r_se = DSE, r_bad.
- Return (combinational, cycle t+1):
  - r_kind=FETCH: IVALID=1, IDATA=MRDATA.
  - Otherwise: IVALID=0, IDATA=NOP_INSN.
  - r_kind=LOAD and not r_bad: DATAI = byte/half selected by r_off from MRDATA, then sign-extended when r_se=1, else zero-extended. Word loads return MRDATA.
  - Otherwise DATAI=0.
- Latency: exactly one cycle for both ports. Back-to-back data accesses stall fetch for every one of those cycles. The core retries by holding IADDR.
- First cycle after reset release: a fetch is issued, IVALID=0. IVALID=1 first appears in cycle 2.
- FSTALL_CNT increments each cycle in which a data request pre-empts a fetch (RSTN=1). It holds at 32'hFFFFFFFF.
- MISALIGN clears only on reset.
- Reset asserted mid-access: r_kind clears asynchronously, so IVALID and DATAI drop the same instant. No partial write beyond the current edge.

Decomposition:
- Package unified_mem_pkg holds:
  - size encodings SZ_NONE/SZ_B/SZ_H/SZ_W
  - the r_kind enum
  - NOP_INSN default
  - the lane-mask function
- One sub-module, mem_lane_align: combinational load extract plus sign/zero extend. Inputs: MRDATA, r_off, r_size, r_se, r_bad. Output: DATAI.

Test Plan:
- Reset release with SRAM word 0 = 32'h00500093, IADDR=0 -> cycle 1 IVALID=0, IDATA=32'h00000013; cycle 2 IVALID=1, IDATA=32'h00500093.
- Store byte DATAO=32'h000000AB, DADDR=0x102, DWE=01 -> MWE=0100, MWDATA=32'hABABABAB, MADDR=0x40. Next cycle IVALID=0, FSTALL_CNT=1.
- Word 0x40 = 32'h80FF7F01:
  - Load half DADDR=0x102, DRE=10, DSE=1 -> next-cycle DATAI=32'hFFFF80FF.
  - Same load with DSE=0 -> DATAI=32'h000080FF.
- Load byte DADDR=0x101, DRE=01, DSE=1 -> DATAI=32'h0000007F. With DADDR=0x103 -> DATAI=32'hFFFFFF80.
- Store word DADDR=0x102, DWE=11 -> MCE=0, no SRAM change, MISALIGN=1 from the next cycle and held until reset.
- Five consecutive loads -> IVALID=0 for 5 cycles, FSTALL_CNT=5. The fetch resumes with IVALID=1 one cycle after the data run. Assert RSTN=0 mid-run -> IVALID, DATAI and FSTALL_CNT go to 0 asynchronously.
